peripheral_msi_arbiter_wb: RTL and testbench

//   Round-robin Wishbone arbiter sharing one slave port (the memory) among NM masters (or1k data,
//   or1k instruction, debug). It grants one master for a whole bus cycle (cyc held, bursts included)
//   and muxes that master onto the slave. Sits between the masters and the shared memory slave.

---
 rtl/peripheral_msi_wb_pkg.sv | 40 ++++
 rtl/peripheral_msi_rr_arbiter.sv | 39 +++
 rtl/peripheral_msi_arbiter_wb.sv | 216 +++++++++++++++++++++
 tb/tb_peripheral_msi_arbiter_wb.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_msi_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_msi_wb_pkg
//  Purpose  : Shared types and constants for the MSI Wishbone arbiter:
//             arbiter FSM state encoding, Wishbone CTI/BTE codes and a
//             helper that sizes the optional watchdog counter.
//  Revision : 1.0 - initial release
// ============================================================================
package peripheral_msi_wb_pkg;

   // Arbiter FSM states; DRAIN is only reachable in the watchdog build
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   // Wishbone cycle-type identifiers
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   // Wishbone burst-type extensions
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Watchdog counter width: enough to hold the limit, clamped to 8..32 bits
   function automatic int timeout_width(input int limit);
      int w;
      w = $clog2(limit + 1);
      if (w < 8)  w = 8;
      if (w > 32) w = 32;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_msi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_msi_rr_arbiter
//  Purpose  : Combinational round-robin picker. Scans the request vector
//             starting just after the previous winner (last) and returns a
//             one-hot grant for the first requester found, or zero.
//  Revision : 1.0 - initial release
// ============================================================================
module peripheral_msi_rr_arbiter
   import peripheral_msi_wb_pkg::*;
#(
   parameter int NM = 3,
   parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic [NM-1:0] req,
   input  logic [LW-1:0] last,
   output logic [NM-1:0] gnt
);

   // Rotating-priority scan: last+1, last+2, ... wrapping modulo NM
   always_comb begin
      logic found;
      int   idx;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= NM; i++) begin
         idx = int'(last) + i;
         if (idx >= NM) idx = idx - NM;
         if (idx >= NM) idx = idx - NM;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/peripheral_msi_arbiter_wb.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_msi_arbiter_wb
//  Purpose  : Round-robin Wishbone arbiter sharing one slave among NM masters
//             (0 = or1k data, 1 = or1k instruction, 2 = debug). A master
//             keeps the slave for its whole cyc window, bursts included.
//  Options  : MSI_ARB_TIMEOUT_EN - adds a stall watchdog that errors out a
//             hung cycle after TIMEOUT stalled cycles and drains the master.
//  Revision : 1.0 - initial release
// ============================================================================
module peripheral_msi_arbiter_wb
   import peripheral_msi_wb_pkg::*;
#(
   parameter int NM      = 3,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_ni,
   // master side
   input  logic [NM*AW-1:0]       wbm_adr_i,
   input  logic [NM*DW-1:0]       wbm_dat_i,
   input  logic [NM*(DW/8)-1:0]   wbm_sel_i,
   input  logic [NM-1:0]          wbm_we_i,
   input  logic [NM-1:0]          wbm_cyc_i,
   input  logic [NM-1:0]          wbm_stb_i,
   input  logic [NM*3-1:0]        wbm_cti_i,
   input  logic [NM*2-1:0]        wbm_bte_i,
   output logic [DW-1:0]          wbm_dat_o,
   output logic [NM-1:0]          wbm_ack_o,
   output logic [NM-1:0]          wbm_err_o,
   output logic [NM-1:0]          wbm_rty_o,
   // slave side
   output logic [AW-1:0]          wbs_adr_o,
   output logic [DW-1:0]          wbs_dat_o,
   output logic [DW/8-1:0]        wbs_sel_o,
   output logic                   wbs_we_o,
   output logic                   wbs_cyc_o,
   output logic                   wbs_stb_o,
   output logic [2:0]             wbs_cti_o,
   output logic [1:0]             wbs_bte_o,
   input  logic [DW-1:0]          wbs_dat_i,
   input  logic                   wbs_ack_i,
   input  logic                   wbs_err_i,
   input  logic                   wbs_rty_i,
   // debug
   output logic [NM-1:0]          grant_o
);

   localparam int SW = DW / 8;
   localparam int LW = (NM > 1) ? $clog2(NM) : 1;
   localparam logic [LW-1:0] LAST_RST = LW'(NM - 1);

   arb_state_t     state_q, state_d;
   logic [NM-1:0]  grant_q, grant_d;
   logic [LW-1:0]  last_q,  last_d;

   logic [NM-1:0]  arb_gnt;
   logic [LW-1:0]  gidx;
   logic           gnt_cyc;
   logic           timeout_hit;

   logic [AW-1:0]  mux_adr;
   logic [DW-1:0]  mux_dat;
   logic [SW-1:0]  mux_sel;
   logic           mux_we;
   logic           mux_cyc;
   logic           mux_stb;
   logic [2:0]     mux_cti;
   logic [1:0]     mux_bte;

   peripheral_msi_rr_arbiter #(
      .NM   (NM),
      .LW   (LW)
   ) u_rr (
      .req  (wbm_cyc_i),
      .last (last_q),
      .gnt  (arb_gnt)
   );

   // Mux the granted master onto the slave; an empty grant yields all zeros
   always_comb begin
      mux_adr = '0;
      mux_dat = '0;
      mux_sel = '0;
      mux_we  = 1'b0;
      mux_cyc = 1'b0;
      mux_stb = 1'b0;
      mux_cti = '0;
      mux_bte = '0;
      gidx    = '0;
      for (int k = 0; k < NM; k++) begin
         if (grant_q[k]) begin
            mux_adr = mux_adr | wbm_adr_i[k*AW +: AW];
            mux_dat = mux_dat | wbm_dat_i[k*DW +: DW];
            mux_sel = mux_sel | wbm_sel_i[k*SW +: SW];
            mux_we  = mux_we  | wbm_we_i[k];
            mux_cyc = mux_cyc | wbm_cyc_i[k];
            mux_stb = mux_stb | wbm_stb_i[k];
            mux_cti = mux_cti | wbm_cti_i[k*3 +: 3];
            mux_bte = mux_bte | wbm_bte_i[k*2 +: 2];
            gidx    = LW'(k);
         end
      end
   end

   assign gnt_cyc = |(grant_q & wbm_cyc_i);

`ifdef MSI_ARB_TIMEOUT_EN
   localparam int CW = timeout_width(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          stalled;

   // A strobe waiting on the slave with no termination this cycle
   assign stalled     = (state_q == GRANT) && mux_cyc && mux_stb &&
                        !(wbs_ack_i || wbs_err_i || wbs_rty_i);
   // Fires on the TIMEOUT-th consecutive stalled cycle
   assign timeout_hit = stalled && (cnt_q == CNT_LAST);

   // Stall counter: clears on any termination or when leaving GRANT
   always_comb begin
      cnt_d = '0;
      if (stalled && !timeout_hit) cnt_d = cnt_q + 1'b1;
   end

   // Stall counter register
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state logic: arbitrate in IDLE, hold grant until the owner drops cyc
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (|wbm_cyc_i) begin
               grant_d = arb_gnt;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!gnt_cyc) begin
               grant_d = '0;
               last_d  = gidx;
               state_d = IDLE;
            end else if (timeout_hit) begin
               state_d = DRAIN;
            end
         end
`ifdef MSI_ARB_TIMEOUT_EN
         DRAIN: begin
            if (!gnt_cyc) begin
               grant_d = '0;
               last_d  = gidx;
               state_d = IDLE;
            end
         end
`endif
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State, grant and rotation pointer registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Slave-side outputs: only live while a grant is active in GRANT
   always_comb begin
      wbs_adr_o = mux_adr;
      wbs_dat_o = mux_dat;
      wbs_sel_o = mux_sel;
      wbs_we_o  = mux_we;
      wbs_cti_o = mux_cti;
      wbs_bte_o = mux_bte;
      wbs_cyc_o = (state_q == GRANT) && mux_cyc && !timeout_hit;
      wbs_stb_o = (state_q == GRANT) && mux_stb && !timeout_hit;
   end

   // Master-side responses: routed only to the granted master
   always_comb begin
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      if (state_q == GRANT) begin
         wbm_ack_o = grant_q & {NM{wbs_ack_i}};
         wbm_err_o = grant_q & {NM{wbs_err_i || timeout_hit}};
         wbm_rty_o = grant_q & {NM{wbs_rty_i}};
      end
   end

   assign wbm_dat_o = wbs_dat_i;
   assign grant_o   = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_msi_arbiter_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peripheral_msi_arbiter_wb
//  Purpose  : Directed self-checking bench for peripheral_msi_arbiter_wb.
//             Inputs change 1 ns after the rising edge; outputs are sampled
//             1 ns after that.
//  Options  : MSI_ARB_TIMEOUT_EN - also exercises the stall watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_msi_arbiter_wb;

   localparam int NM = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic                wb_clk_i;
   logic                wb_rst_ni;
   logic [NM*AW-1:0]    m_adr;
   logic [NM*DW-1:0]    m_dat;
   logic [NM*SW-1:0]    m_sel;
   logic [NM-1:0]       m_we;
   logic [NM-1:0]       m_cyc;
   logic [NM-1:0]       m_stb;
   logic [NM*3-1:0]     m_cti;
   logic [NM*2-1:0]     m_bte;
   logic [DW-1:0]       wbm_dat_o;
   logic [NM-1:0]       wbm_ack_o;
   logic [NM-1:0]       wbm_err_o;
   logic [NM-1:0]       wbm_rty_o;
   logic [AW-1:0]       wbs_adr_o;
   logic [DW-1:0]       wbs_dat_o;
   logic [SW-1:0]       wbs_sel_o;
   logic                wbs_we_o;
   logic                wbs_cyc_o;
   logic                wbs_stb_o;
   logic [2:0]          wbs_cti_o;
   logic [1:0]          wbs_bte_o;
   logic [DW-1:0]       s_dat;
   logic                s_ack;
   logic                s_err;
   logic                s_rty;
   logic [NM-1:0]       grant_o;

   int checks = 0;
   int errors = 0;

   peripheral_msi_arbiter_wb #(
      .NM(NM), .AW(AW), .DW(DW), .TIMEOUT(8)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .wbm_adr_i (m_adr),
      .wbm_dat_i (m_dat),
      .wbm_sel_i (m_sel),
      .wbm_we_i  (m_we),
      .wbm_cyc_i (m_cyc),
      .wbm_stb_i (m_stb),
      .wbm_cti_i (m_cti),
      .wbm_bte_i (m_bte),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_o (wbm_ack_o),
      .wbm_err_o (wbm_err_o),
      .wbm_rty_o (wbm_rty_o),
      .wbs_adr_o (wbs_adr_o),
      .wbs_dat_o (wbs_dat_o),
      .wbs_sel_o (wbs_sel_o),
      .wbs_we_o  (wbs_we_o),
      .wbs_cyc_o (wbs_cyc_o),
      .wbs_stb_o (wbs_stb_o),
      .wbs_cti_o (wbs_cti_o),
      .wbs_bte_o (wbs_bte_o),
      .wbs_dat_i (s_dat),
      .wbs_ack_i (s_ack),
      .wbs_err_i (s_err),
      .wbs_rty_i (s_rty),
      .grant_o   (grant_o)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   // Absolute bound on the run
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
      m_cyc[k]            = cyc;
      m_stb[k]            = stb;
      m_we[k]             = we;
      m_adr[k*AW +: AW]   = adr;
      m_dat[k*DW +: DW]   = dat;
      m_sel[k*SW +: SW]   = '1;
      m_cti[k*3 +: 3]     = cti;
      m_bte[k*2 +: 2]     = 2'b00;
   endtask

   task automatic reset_dut();
      wb_rst_ni = 1'b0;
      m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
      m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
      s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      repeat (2) @(posedge wb_clk_i);
      #1;
      wb_rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      reset_dut();
      #1;
      checks++;
      if (grant_o !== 3'b000 || wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0 || wbs_adr_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: grant=%b cyc=%b stb=%b adr=%h, want 000 0 0 0", grant_o, wbs_cyc_o, wbs_stb_o, wbs_adr_o);
      end
      checks++;
      if (wbm_ack_o !== 3'b000 || wbm_err_o !== 3'b000 || wbm_rty_o !== 3'b000) begin
         errors++;
         $display("FAIL reset_resp: ack=%b err=%b rty=%b, want 000", wbm_ack_o, wbm_err_o, wbm_rty_o);
      end
      // open a cycle, then pull reset in the middle of it
      set_m(1, 1'b1, 1'b1, 1'b1, 32'h40, 32'hA5A5_A5A5, 3'b000);
      step();
      checks++;
      if (grant_o !== 3'b010 || wbs_cyc_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_grant: grant=%b cyc=%b, want 010 1", grant_o, wbs_cyc_o);
      end
      #2;
      wb_rst_ni = 1'b0;
      #1;
      checks++;
      if (grant_o !== 3'b000 || wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0 ||
          wbs_we_o !== 1'b0 || wbs_adr_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_async: grant=%b cyc=%b stb=%b we=%b adr=%h, want all 0",
                  grant_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o);
      end
      reset_dut();
   endtask

   task automatic test_single_read();
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 3'b000);
      #1;
      checks++;
      if (grant_o !== 3'b000 || wbs_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL read_latency: grant=%b cyc=%b before edge, want 000 0", grant_o, wbs_cyc_o);
      end
      step();
      checks++;
      if (grant_o !== 3'b010 || wbs_cyc_o !== 1'b1 || wbs_stb_o !== 1'b1 || wbs_adr_o !== 32'h100) begin
         errors++;
         $display("FAIL read_grant: grant=%b cyc=%b stb=%b adr=%h, want 010 1 1 00000100",
                  grant_o, wbs_cyc_o, wbs_stb_o, wbs_adr_o);
      end
      s_ack = 1'b1;
      s_dat = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (wbm_ack_o !== 3'b010 || wbm_dat_o !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL read_ack: ack=%b dat=%h, want 010 deadbeef", wbm_ack_o, wbm_dat_o);
      end
      step();
      s_ack = 1'b0;
      set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      step();
      checks++;
      if (grant_o !== 3'b000 || wbs_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL read_release: grant=%b cyc=%b, want 000 0", grant_o, wbs_cyc_o);
      end
   endtask

   task automatic test_round_robin();
      logic [NM-1:0] exp_g [4];
      int            idx   [4];
      exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
      idx[0] = 0; idx[1] = 1; idx[2] = 2; idx[3] = 0;
      reset_dut();
      for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(k), 32'h0, 3'b000);
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (grant_o !== exp_g[i]) begin
            errors++;
            $display("FAIL rr_order[%0d]: grant=%b, want %b", i, grant_o, exp_g[i]);
         end
         s_ack = 1'b1;
         #1;
         checks++;
         if (wbm_ack_o !== exp_g[i]) begin
            errors++;
            $display("FAIL rr_ack[%0d]: ack=%b, want %b", i, wbm_ack_o, exp_g[i]);
         end
         step();
         s_ack = 1'b0;
         set_m(idx[i], 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
         if (i == 2) set_m(0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h0, 3'b000);
         step();
         checks++;
         if (grant_o !== 3'b000) begin
            errors++;
            $display("FAIL rr_idle[%0d]: grant=%b, want 000", i, grant_o);
         end
      end
   endtask

   task automatic test_burst();
      int acks;
      reset_dut();
      acks = 0;
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
      set_m(2, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 3'b000);
      step();
      for (int b = 0; b < 4; b++) begin
         set_m(0, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4*b), 32'h0, (b == 3) ? 3'b111 : 3'b010);
         s_ack = 1'b1;
         #1;
         if (wbm_ack_o === 3'b001 && grant_o === 3'b001) acks++;
         checks++;
         if (wbs_adr_o !== 32'h200 + 32'(4*b) || wbs_cti_o !== ((b == 3) ? 3'b111 : 3'b010)) begin
            errors++;
            $display("FAIL burst_beat[%0d]: adr=%h cti=%b", b, wbs_adr_o, wbs_cti_o);
         end
         step();
      end
      checks++;
      if (acks != 4) begin
         errors++;
         $display("FAIL burst_acks: got %0d acks to m0, want 4", acks);
      end
      s_ack = 1'b0;
      set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      #1;
      checks++;
      if (grant_o !== 3'b001) begin
         errors++;
         $display("FAIL burst_hold: grant=%b, want 001", grant_o);
      end
      step();
      step();
      checks++;
      if (grant_o !== 3'b100 || wbs_adr_o !== 32'h300) begin
         errors++;
         $display("FAIL burst_next: grant=%b adr=%h, want 100 00000300", grant_o, wbs_adr_o);
      end
      set_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      step();
      step();
   endtask

   task automatic test_err_rty();
      set_m(2, 1'b1, 1'b1, 1'b1, 32'h80, 32'h1234_5678, 3'b000);
      step();
      checks++;
      if (grant_o !== 3'b100 || wbs_we_o !== 1'b1 || wbs_dat_o !== 32'h1234_5678 || wbs_sel_o !== 4'hF) begin
         errors++;
         $display("FAIL write_mux: grant=%b we=%b dat=%h sel=%h, want 100 1 12345678 f",
                  grant_o, wbs_we_o, wbs_dat_o, wbs_sel_o);
      end
      s_err = 1'b1;
      #1;
      checks++;
      if (wbm_err_o !== 3'b100 || wbm_ack_o !== 3'b000 || wbm_rty_o !== 3'b000) begin
         errors++;
         $display("FAIL err_route: err=%b ack=%b rty=%b, want 100 000 000", wbm_err_o, wbm_ack_o, wbm_rty_o);
      end
      s_err = 1'b0;
      s_rty = 1'b1;
      #1;
      checks++;
      if (wbm_rty_o !== 3'b100 || wbm_err_o !== 3'b000) begin
         errors++;
         $display("FAIL rty_route: rty=%b err=%b, want 100 000", wbm_rty_o, wbm_err_o);
      end
      step();
      s_rty = 1'b0;
      set_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      step();
      s_dat = 32'h0BAD_F00D;
      #1;
      checks++;
      if (wbm_dat_o !== 32'h0BAD_F00D || wbm_err_o !== 3'b000) begin
         errors++;
         $display("FAIL dat_bcast: dat=%h err=%b, want 0badf00d 000", wbm_dat_o, wbm_err_o);
      end
   endtask

`ifdef MSI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int early;
      reset_dut();
      early = 0;
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 3'b000);
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 3'b000);
      step();
      for (int s = 1; s <= 7; s++) begin
         if (wbm_err_o !== 3'b000 || wbs_cyc_o !== 1'b1) early++;
         step();
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL timeout_early: %0d of 7 stalled cycles had err or no cyc, want 0", early);
      end
      checks++;
      if (wbm_err_o !== 3'b001 || wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fire: err=%b cyc=%b stb=%b, want 001 0 0", wbm_err_o, wbs_cyc_o, wbs_stb_o);
      end
      step();
      checks++;
      if (wbm_err_o !== 3'b000 || wbs_cyc_o !== 1'b0 || grant_o !== 3'b001) begin
         errors++;
         $display("FAIL timeout_drain: err=%b cyc=%b grant=%b, want 000 0 001", wbm_err_o, wbs_cyc_o, grant_o);
      end
      set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      step();
      step();
      checks++;
      if (grant_o !== 3'b010 || wbs_cyc_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_next: grant=%b cyc=%b, want 010 1", grant_o, wbs_cyc_o);
      end
      set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      step();
   endtask
`else
   task automatic test_hung_slave();
      int lost;
      reset_dut();
      lost = 0;
      set_m(0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 3'b000);
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 3'b000);
      step();
      for (int s = 0; s < 20; s++) begin
         if (grant_o !== 3'b001 || wbs_cyc_o !== 1'b1 || wbm_err_o !== 3'b000) lost++;
         step();
      end
      checks++;
      if (lost != 0) begin
         errors++;
         $display("FAIL hung_hold: grant lost or err seen in %0d of 20 cycles, want 0", lost);
      end
      set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      step();
      step();
      checks++;
      if (grant_o !== 3'b010) begin
         errors++;
         $display("FAIL hung_next: grant=%b, want 010", grant_o);
      end
      set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_burst();
      test_err_rty();
`ifdef MSI_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_hung_slave();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
